// File: rtl/dbg_pkg.sv
// Shared types for the debug step-clock controller: FSM states and
// the run-mode encodings that come in on the mode switches.
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_BURST  = 2'b01;
    localparam logic [1:0] MODE_RUN    = 2'b10;

    // The unused switch setting 2'b11 behaves exactly like single step,
    // so it is folded into MODE_SINGLE at the moment the mode is latched.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_SINGLE : m;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the HIGH and LOW phases of each
// generated step. tc is high while the count sits at zero, which marks
// the last cycle of the phase that was loaded.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // A load always wins; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/step_clk_ctrl.sv
// Debug clock generator for the board-level CPU: turns debounced key
// pulses into single steps, fixed-length bursts or a free-running clock,
// and halts when the CPU PC reaches a breakpoint address.
module step_clk_ctrl
    import dbg_pkg::*;
#(
    parameter int PC_W       = 5,
    parameter int HIGH_CYC   = 4,
    parameter int RUN_PERIOD = 25000000,
    parameter int BURST_LEN  = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop,
    input  logic             sw_pulse,
    input  logic [1:0]       mode,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc_in,
    output logic             step_clk,
    output logic             busy,
    output logic             halted_bp,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int PH_W = $clog2(RUN_PERIOD);
    localparam int BC_W = $clog2(BURST_LEN) + 1;

    // Timer load values are "phase length minus one" because the timer
    // flags its last cycle at a count of zero.
    localparam logic [PH_W-1:0] HIGH_LOAD    = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0] LOW_SB_LOAD  = PH_W'(HIGH_CYC - 1);
    localparam logic [PH_W-1:0] LOW_RUN_LOAD = PH_W'(RUN_PERIOD - HIGH_CYC - 1);
    localparam logic [BC_W-1:0] BURST_LAST   = BC_W'(BURST_LEN - 1);

    state_t            state_q,     state_d;
    logic [1:0]        mode_r_q,    mode_r_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic              stop_req_q,  stop_req_d;
    logic              step_clk_q,  step_clk_d;
    logic              busy_q,      busy_d;
    logic              halted_bp_q, halted_bp_d;
    logic [CNT_W-1:0]  step_cnt_q,  step_cnt_d;

    logic              timer_load;
    logic [PH_W-1:0]   timer_val;
    logic              phase_done;
    logic              bp_hit;

    phase_timer #(
        .W (PH_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (phase_done)
    );

    // pc_in is only looked at on the final LOW cycle, long after the CPU's
    // rising edge, so its value has settled by then.
    assign bp_hit = bp_en && (pc_in == bp_addr);

    // Next-state logic for the step FSM, its bookkeeping and the registered
    // outputs, all derived from where the FSM is heading next.
    always_comb begin
        state_d     = state_q;
        mode_r_d    = mode_r_q;
        burst_cnt_d = burst_cnt_q;
        stop_req_d  = stop_req_q;
        timer_load  = 1'b0;
        timer_val   = HIGH_LOAD;

        case (state_q)
            IDLE: begin
                if (sw_pulse && !stop) begin
                    mode_r_d    = norm_mode(mode);
                    burst_cnt_d = '0;
                    state_d     = HIGH;
                    timer_load  = 1'b1;
                    timer_val   = HIGH_LOAD;
                end
            end

            HIGH: begin
                if (sw_pulse && (mode_r_q == MODE_RUN)) begin
                    stop_req_d = 1'b1;
                end
                if (phase_done) begin
                    state_d    = LOW;
                    timer_load = 1'b1;
                    timer_val  = (mode_r_q == MODE_RUN) ? LOW_RUN_LOAD : LOW_SB_LOAD;
                end
            end

            LOW: begin
                if (sw_pulse && (mode_r_q == MODE_RUN)) begin
                    stop_req_d = 1'b1;
                end
                if (phase_done) begin
                    if (bp_hit) begin
                        state_d = HALT;
                    end else if (stop) begin
                        state_d = IDLE;
                    end else if (mode_r_q == MODE_BURST) begin
                        if (burst_cnt_q == BURST_LAST) begin
                            state_d = IDLE;
                        end else begin
                            burst_cnt_d = burst_cnt_q + 1'b1;
                            state_d     = HIGH;
                            timer_load  = 1'b1;
                            timer_val   = HIGH_LOAD;
                        end
                    end else if (mode_r_q == MODE_RUN) begin
                        if (stop_req_d) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = HIGH;
                            timer_load = 1'b1;
                            timer_val  = HIGH_LOAD;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            HALT: begin
                if (sw_pulse) begin
                    mode_r_d    = MODE_SINGLE;
                    burst_cnt_d = '0;
                    state_d     = HIGH;
                    timer_load  = 1'b1;
                    timer_val   = HIGH_LOAD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            stop_req_d = 1'b0;
        end

        step_clk_d  = (state_d == HIGH);
        busy_d      = (state_d == HIGH) || (state_d == LOW);
        halted_bp_d = (state_d == HALT);

        step_cnt_d = step_cnt_q;
        if ((state_d == HIGH) && (state_q != HIGH) && (step_cnt_q != '1)) begin
            step_cnt_d = step_cnt_q + 1'b1;
        end
    end

    // State and output registers; reset truncates any pulse in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_r_q    <= MODE_SINGLE;
            burst_cnt_q <= '0;
            stop_req_q  <= 1'b0;
            step_clk_q  <= 1'b0;
            busy_q      <= 1'b0;
            halted_bp_q <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_r_q    <= mode_r_d;
            burst_cnt_q <= burst_cnt_d;
            stop_req_q  <= stop_req_d;
            step_clk_q  <= step_clk_d;
            busy_q      <= busy_d;
            halted_bp_q <= halted_bp_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign step_clk  = step_clk_q;
    assign busy      = busy_q;
    assign halted_bp = halted_bp_q;
    assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Bench for step_clk_ctrl: a step-level model predicts every output on
// every cycle, and directed scenarios pin key values with literals.
module tb_step_clk_ctrl;

    localparam int PC_W       = 5;
    localparam int HIGH_CYC   = 2;
    localparam int RUN_PERIOD = 10;
    localparam int BURST_LEN  = 4;
    localparam int CNT_W      = 16;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             stop     = 1'b0;
    logic             sw_pulse = 1'b0;
    logic [1:0]       mode     = 2'b00;
    logic             bp_en    = 1'b0;
    logic [PC_W-1:0]  bp_addr  = '0;
    logic [PC_W-1:0]  pc_in;
    logic             step_clk;
    logic             busy;
    logic             halted_bp;
    logic [CNT_W-1:0] step_cnt;

    int checks = 0;
    int errors = 0;

    logic pc_clear = 1'b0;
    int   cpu_pc   = 0;

    // Model step state: whether a step is in progress, where in it we are,
    // how long it lasts, what kind of run started it, and total steps.
    bit m_in_step  = 1'b0;
    bit m_halted   = 1'b0;
    bit m_stop_req = 1'b0;
    int m_pos      = 0;
    int m_period   = 0;
    int m_kind     = 0;
    int m_bursts   = 0;
    int m_steps    = 0;

    step_clk_ctrl #(
        .PC_W       (PC_W),
        .HIGH_CYC   (HIGH_CYC),
        .RUN_PERIOD (RUN_PERIOD),
        .BURST_LEN  (BURST_LEN),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stop      (stop),
        .sw_pulse  (sw_pulse),
        .mode      (mode),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc_in     (pc_in),
        .step_clk  (step_clk),
        .busy      (busy),
        .halted_bp (halted_bp),
        .step_cnt  (step_cnt)
    );

    // Free-running board clock.
    always #5 clk = ~clk;

    // Stand-in CPU: its PC advances on every rising edge of the step clock.
    always @(posedge step_clk or posedge pc_clear) begin
        if (pc_clear) cpu_pc <= 0;
        else          cpu_pc <= cpu_pc + 1;
    end

    assign pc_in = cpu_pc[PC_W-1:0];

    function automatic void start_step();
        m_in_step = 1'b1;
        m_pos     = 0;
        m_period  = (m_kind == 2) ? RUN_PERIOD : 2 * HIGH_CYC;
        if (m_steps < 65535) m_steps = m_steps + 1;
    endfunction

    // One board-clock step of the model, following the step rules directly.
    function automatic void model_update();
        if (rst) begin
            m_in_step  = 1'b0;
            m_halted   = 1'b0;
            m_stop_req = 1'b0;
            m_pos      = 0;
            m_bursts   = 0;
            m_steps    = 0;
        end else if (m_in_step) begin
            if (m_kind == 2 && sw_pulse) m_stop_req = 1'b1;
            if (m_pos == m_period - 1) begin
                m_in_step = 1'b0;
                if (bp_en && pc_in == bp_addr) begin
                    m_halted = 1'b1;
                end else if (stop || m_kind == 0) begin
                    m_halted = 1'b0;
                end else if (m_kind == 1) begin
                    if (m_bursts != BURST_LEN - 1) begin
                        m_bursts = m_bursts + 1;
                        start_step();
                    end
                end else if (!m_stop_req) begin
                    start_step();
                end
                if (!m_in_step && !m_halted) m_stop_req = 1'b0;
            end else begin
                m_pos = m_pos + 1;
            end
        end else if (m_halted) begin
            if (sw_pulse) begin
                m_halted = 1'b0;
                m_kind   = 0;
                start_step();
            end
        end else if (sw_pulse && !stop) begin
            m_kind   = (mode == 2'b01) ? 1 : (mode == 2'b10) ? 2 : 0;
            m_bursts = 0;
            start_step();
        end
    endfunction

    // Advance the model on each active edge, after inputs settled at negedge.
    initial begin
        forever begin
            @(posedge clk);
            model_update();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model once per cycle.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("m_step_clk", step_clk, (m_in_step && m_pos < HIGH_CYC) ? 1 : 0);
            checkOutput("m_busy", busy, m_in_step ? 1 : 0);
            checkOutput("m_halted_bp", halted_bp, m_halted ? 1 : 0);
            checkOutput("m_step_cnt", step_cnt, m_steps);
        end
    end

    task automatic applyStimulus(input logic [1:0] m);
        @(negedge clk);
        mode     = m;
        sw_pulse = 1'b1;
        @(negedge clk);
        sw_pulse = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst      = 1'b1;
        pc_clear = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        pc_clear = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput("wait_idle", busy, 0);
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (halted_bp !== 1'b1 && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput("wait_halt", halted_bp, 1);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios with literal expectations.
    initial begin
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_step_clk", step_clk, 0);
        checkOutput("reset_step_cnt", step_cnt, 0);
        tick(3);

        // Single step: one-cycle latency, HIGH_CYC high, HIGH_CYC low.
        applyStimulus(2'b00);
        checkOutput("single_hi1", step_clk, 1);
        sw_pulse = 1'b1;
        @(negedge clk);
        sw_pulse = 1'b0;
        checkOutput("single_hi2", step_clk, 1);
        @(negedge clk);
        checkOutput("single_lo1", step_clk, 0);
        checkOutput("single_busy_lo", busy, 1);
        tick(2);
        checkOutput("single_busy_end", busy, 0);
        checkOutput("single_cnt", step_cnt, 1);

        // Mode 11 behaves like single.
        applyStimulus(2'b11);
        wait_idle(20);
        checkOutput("mode3_cnt", step_cnt, 2);

        // Burst of four, twice.
        reset_dut();
        applyStimulus(2'b01);
        wait_idle(40);
        checkOutput("burst1_cnt", step_cnt, 4);
        checkOutput("burst1_edges", cpu_pc, 4);
        applyStimulus(2'b01);
        wait_idle(40);
        checkOutput("burst2_cnt", step_cnt, 8);
        checkOutput("burst2_edges", cpu_pc, 8);

        // Run mode stopped by a key press during the second LOW phase.
        reset_dut();
        applyStimulus(2'b10);
        tick(13);
        applyStimulus(2'b10);
        wait_idle(40);
        tick(25);
        checkOutput("run_cnt", step_cnt, 2);
        checkOutput("run_edges", cpu_pc, 2);

        // Breakpoint at PC 3 in run mode, then one step out of HALT.
        reset_dut();
        bp_en   = 1'b1;
        bp_addr = 5'd3;
        applyStimulus(2'b10);
        wait_halt(100);
        checkOutput("bp_step_clk", step_clk, 0);
        checkOutput("bp_cnt", step_cnt, 3);
        checkOutput("bp_pc", cpu_pc, 3);
        tick(5);
        checkOutput("bp_hold", halted_bp, 1);
        applyStimulus(2'b10);
        wait_idle(20);
        checkOutput("bp_resume_halt", halted_bp, 0);
        checkOutput("bp_resume_cnt", step_cnt, 4);
        checkOutput("bp_resume_pc", cpu_pc, 4);

        // Stop and breakpoint together: HALT wins; stop ignored in HALT;
        // stop held in IDLE blocks the key.
        reset_dut();
        bp_addr = 5'd1;
        applyStimulus(2'b00);
        stop = 1'b1;
        wait_halt(20);
        tick(3);
        checkOutput("stopbp_hold", halted_bp, 1);
        applyStimulus(2'b00);
        wait_idle(20);
        checkOutput("stopbp_cnt", step_cnt, 2);
        applyStimulus(2'b00);
        checkOutput("stop_idle_busy", busy, 0);
        tick(5);
        checkOutput("stop_idle_cnt", step_cnt, 2);
        stop  = 1'b0;
        bp_en = 1'b0;

        // Reset in the middle of a burst HIGH phase, then a clean restart.
        reset_dut();
        applyStimulus(2'b01);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_step_clk", step_clk, 0);
        checkOutput("midrst_cnt", step_cnt, 0);
        checkOutput("midrst_busy", busy, 0);
        rst = 1'b0;
        applyStimulus(2'b01);
        checkOutput("restart_hi", step_clk, 1);
        checkOutput("restart_cnt1", step_cnt, 1);
        wait_idle(40);
        checkOutput("restart_cnt4", step_cnt, 4);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
